way_evict_controller: RTL
=========================

Name: way_evict_controller

Overview:
Counterpart to the write-side way selector. It frees a way in one cache set so the write path can fill it. If the set still has an invalid way, it reports the lowest-indexed one and changes nothing. If the set is full, it picks a victim using a per-set round-robin pointer, runs a writeback handshake when the victim is dirty, then clears the victim's valid bit. It sits between the cache controller FSM and the writeback/memory port.

Parameters:
NWAYS, 5, number of ways per set (need not be a power of 2)
NSETS, 16, number of sets; one round-robin pointer is kept per set

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
evict_req  input  1  request to free a way in set set_idx; sampled only in IDLE
set_idx  input  $clog2(NSETS)  target set; captured with evict_req
valid_bits_in  input  NWAYS  valid bits of the target set; captured with evict_req
dirty_bits_in  input  NWAYS  dirty bits of the target set; captured with evict_req
busy  output  1  high in every state except IDLE
wb_req  output  1  writeback request for a dirty victim
wb_way  output  $clog2(NWAYS)  way being written back; valid while wb_req=1
wb_ack  input  1  writeback complete; only honoured in WB
evict_done  output  1  one-cycle completion pulse
victim_way  output  $clog2(NWAYS)  way freed or found free
evicted  output  1  1 = a valid way was invalidated; 0 = a free way already existed
valid_bits_out  output  NWAYS  valid bits of the set after the operation

Behaviour:
- Reset: FSM goes to IDLE and all rr_ptr entries go to 0. busy, wb_req, wb_way, evict_done, victim_way, evicted and valid_bits_out all go to 0.
- All outputs are registered. States are IDLE, SELECT, WB, INVAL and DONE.
- IDLE:
  - On evict_req=1, capture set_idx, valid_bits_in and dirty_bits_in, then go to SELECT.
  - evict_req in any other state is ignored; it is neither queued nor acknowledged.
- SELECT (1 cycle), when the captured valid bits are not all 1:
  - victim = lowest index i with valid[i]=0, evicted=0.
  - valid_bits_out = captured valid bits, unchanged.
  - Go to DONE.
- SELECT, when the captured valid bits are all 1:
  - victim = rr_ptr[set].
  - Go to WB if dirty[victim]=1, otherwise go to INVAL.
- WB:
  - wb_req=1 and wb_way=victim, both held stable until wb_ack=1 is sampled.
  - On wb_ack=1, go to INVAL; wb_req drops in the same cycle INVAL is entered.
  - There is no timeout.
- INVAL (1 cycle):
  - valid_bits_out = captured valid bits with bit [victim] cleared, evicted=1.
  - rr_ptr[set] = (victim == NWAYS-1) ? 0 : victim+1. The wrap is explicit and never relies on natural overflow for non-power-of-2 NWAYS.
  - Go to DONE.
- DONE:
  - evict_done=1 for exactly one cycle; victim_way is valid in the same cycle.
  - Go to IDLE.
  - victim_way, evicted and valid_bits_out hold their values until the next request is captured.
- Latency, counted from the cycle evict_req is sampled:
  - Free way available: evict_done 2 cycles later.
  - Clean eviction: evict_done 3 cycles later.
  - Dirty eviction: evict_done 3 cycles plus the number of WB cycles.
- The rr_ptr of a set advances only on an actual eviction; finding a free way leaves it untouched. Pointers of different sets are independent.
- Reset mid-operation (any state):
  - The operation is aborted: no evict_done, and wb_req is low after the reset edge.
  - All rr_ptr entries return to 0.
- wb_ack outside WB has no effect.

Test Plan:
- Free way found: reset, then evict_req with set_idx=3, valid=5'b10111 -> evict_done 2 cycles later, victim_way=3, evicted=0, valid_bits_out=5'b10111, wb_req never asserted.
- Round-robin wrap: set 2 with valid=5'b11111, dirty=0, six back-to-back requests -> victims 0,1,2,3,4,0. Each evict_done comes 3 cycles after its request, and valid_bits_out has exactly the victim bit cleared (first: 5'b11110).
- Dirty writeback stall: set 0 full, dirty=5'b00001 -> wb_req=1, wb_way=0. Hold wb_ack=0 for 4 cycles: wb_req stays high and evict_done stays low. Pulse wb_ack: evict_done 2 cycles later with valid_bits_out=5'b11110, evicted=1.
- Per-set independence: evict full set 1 twice (victims 0,1), then evict full set 5 once -> set 5 victim=0. A further set 1 eviction gives victim=2.
- Reset in WB: with wb_req=1, assert rst for one cycle -> wb_req=0 and busy=0 after the edge, no evict_done. The next eviction on the same full set gives victim=0.
- Ignored inputs:
  - evict_req pulsed while busy=1 (in SELECT and in WB) -> no second evict_done, and captured set/valid values are unchanged.
  - wb_ack=1 while in IDLE -> no state change.

Source files
------------

// File: rtl/way_evict_controller.sv
// Frees one way of a cache set: reports the lowest free way, or evicts the
// round-robin victim (with optional writeback) and clears its valid bit.
module way_evict_controller #(
    parameter int unsigned NWAYS = 5,
    parameter int unsigned NSETS = 16,
    localparam int unsigned WAY_W = $clog2(NWAYS),
    localparam int unsigned SET_W = $clog2(NSETS)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             evict_req_i,
    input  logic [SET_W-1:0] set_idx_i,
    input  logic [NWAYS-1:0] valid_bits_in_i,
    input  logic [NWAYS-1:0] dirty_bits_in_i,
    output logic             busy_o,
    output logic             wb_req_o,
    output logic [WAY_W-1:0] wb_way_o,
    input  logic             wb_ack_i,
    output logic             evict_done_o,
    output logic [WAY_W-1:0] victim_way_o,
    output logic             evicted_o,
    output logic [NWAYS-1:0] valid_bits_out_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_WB,
        S_INVAL,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [SET_W-1:0]   set_q, set_d;
    logic [NWAYS-1:0]   valid_q, valid_d;
    logic [NWAYS-1:0]   dirty_q, dirty_d;
    logic [WAY_W-1:0]   victim_way_q, victim_way_d;
    logic [WAY_W-1:0]   wb_way_q, wb_way_d;
    logic               evicted_q, evicted_d;
    logic [NWAYS-1:0]   valid_out_q, valid_out_d;
    logic               busy_q, busy_d;
    logic               wb_req_q, wb_req_d;
    logic               done_q, done_d;
    logic [WAY_W-1:0]   rr_ptr_q [NSETS];

    logic               rr_we_c;
    logic [WAY_W-1:0]   rr_next_c;
    logic [WAY_W-1:0]   rr_cur_c;
    logic [WAY_W-1:0]   free_way_c;

    assign rr_cur_c = rr_ptr_q[set_q];

    // Lowest-indexed invalid way of the captured set.
    always_comb begin
        free_way_c = '0;
        for (int i = int'(NWAYS) - 1; i >= 0; i--) begin
            if (!valid_q[i]) free_way_c = WAY_W'(i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            set_q        <= '0;
            valid_q      <= '0;
            dirty_q      <= '0;
            victim_way_q <= '0;
            wb_way_q     <= '0;
            evicted_q    <= 1'b0;
            valid_out_q  <= '0;
            busy_q       <= 1'b0;
            wb_req_q     <= 1'b0;
            done_q       <= 1'b0;
            for (int unsigned s = 0; s < NSETS; s++) rr_ptr_q[s] <= '0;
        end else begin
            state_q      <= state_d;
            set_q        <= set_d;
            valid_q      <= valid_d;
            dirty_q      <= dirty_d;
            victim_way_q <= victim_way_d;
            wb_way_q     <= wb_way_d;
            evicted_q    <= evicted_d;
            valid_out_q  <= valid_out_d;
            busy_q       <= busy_d;
            wb_req_q     <= wb_req_d;
            done_q       <= done_d;
            if (rr_we_c) rr_ptr_q[set_q] <= rr_next_c;
        end
    end

    always_comb begin
        state_d      = state_q;
        set_d        = set_q;
        valid_d      = valid_q;
        dirty_d      = dirty_q;
        victim_way_d = victim_way_q;
        wb_way_d     = wb_way_q;
        evicted_d    = evicted_q;
        valid_out_d  = valid_out_q;
        rr_we_c      = 1'b0;
        rr_next_c    = '0;

        case (state_q)
            S_IDLE: begin
                if (evict_req_i) begin
                    set_d   = set_idx_i;
                    valid_d = valid_bits_in_i;
                    dirty_d = dirty_bits_in_i;
                    state_d = S_SELECT;
                end
            end
            S_SELECT: begin
                if (!(&valid_q)) begin
                    victim_way_d = free_way_c;
                    evicted_d    = 1'b0;
                    valid_out_d  = valid_q;
                    state_d      = S_DONE;
                end else begin
                    victim_way_d = rr_cur_c;
                    wb_way_d     = rr_cur_c;
                    state_d      = dirty_q[rr_cur_c] ? S_WB : S_INVAL;
                end
            end
            S_WB: begin
                if (wb_ack_i) state_d = S_INVAL;
            end
            S_INVAL: begin
                valid_out_d = valid_q & ~(NWAYS'(1) << victim_way_q);
                evicted_d   = 1'b1;
                rr_we_c     = 1'b1;
                // Explicit wrap: NWAYS need not be a power of two.
                rr_next_c   = (victim_way_q == WAY_W'(NWAYS - 1)) ? '0
                                                                  : victim_way_q + WAY_W'(1);
                state_d     = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d   = (state_d != S_IDLE);
        wb_req_d = (state_d == S_WB);
        done_d   = (state_d == S_DONE);
    end

    assign busy_o           = busy_q;
    assign wb_req_o         = wb_req_q;
    assign wb_way_o         = wb_way_q;
    assign evict_done_o     = done_q;
    assign victim_way_o     = victim_way_q;
    assign evicted_o        = evicted_q;
    assign valid_bits_out_o = valid_out_q;

endmodule
